// File: rtl/biu_refill_ctrl.sv
// Line-refill controller: round-robin arbitration of two miss ports, one burst read per
// line, beats streamed into the entry buffer, then a tag-install pulse plus requester ack.
module biu_refill_ctrl #(
    parameter int LINE_WORDS  = 8,
    parameter int CNT_WIDTH   = $clog2(LINE_WORDS),
    parameter int LINE_OFFSET = $clog2(LINE_WORDS) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [31:0]          req0_addr,
    output logic                 req0_ack,
    input  logic                 req1_valid,
    input  logic [31:0]          req1_addr,
    output logic                 req1_ack,
    output logic                 req_err,
    output logic                 bus_req,
    output logic [31:0]          bus_addr,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_err,
    output logic                 buf_we,
    output logic [CNT_WIDTH-1:0] buf_waddr,
    output logic [31:0]          buf_wdata,
    output logic                 line_refill,
    output logic [31:0]          refill_pa,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    // Handshakes: a request is held valid until its 1-cycle ack; bus address phase completes
    // on bus_req && bus_gnt; a data beat is accepted on any DATA cycle with bus_rvalid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_FILL  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(LINE_WORDS - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_rr_ptr;
    logic                 r_winner;
    logic [31:0]          r_line_addr;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_grant;
    logic                 w_grant_id;
    logic [31:0]          w_sel_addr;
    logic                 w_beat;

    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        if (r_state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant    = 1'b1;
                w_grant_id = r_rr_ptr;
            end else if (req0_valid) begin
                w_grant    = 1'b1;
                w_grant_id = 1'b0;
            end else if (req1_valid) begin
                w_grant    = 1'b1;
                w_grant_id = 1'b1;
            end
        end
    end

    assign w_sel_addr = w_grant_id ? req1_addr : req0_addr;
    // A bus error in the same cycle as a beat suppresses that beat's buffer write.
    assign w_beat = (r_state == S_DATA) && bus_rvalid && !bus_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ADDR;
            S_ADDR: begin
                if (bus_err)      w_next = S_ABORT;
                else if (bus_gnt) w_next = S_DATA;
            end
            S_DATA: begin
                if (bus_err)                            w_next = S_ABORT;
                else if (bus_rvalid && r_cnt == LAST_BEAT) w_next = S_FILL;
            end
            S_FILL:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 1'b0;
            r_winner    <= 1'b0;
            r_line_addr <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_winner    <= w_grant_id;
                r_rr_ptr    <= ~w_grant_id;
                r_line_addr <= {w_sel_addr[31:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                r_cnt       <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Outputs decode the registered state; only the buffer write port passes bus data through.
    assign bus_req     = (r_state == S_ADDR);
    assign bus_addr    = (r_state == S_ADDR) ? r_line_addr : '0;
    assign line_refill = (r_state == S_FILL);
    assign refill_pa   = (r_state == S_FILL) ? r_line_addr : '0;
    assign req0_ack    = ((r_state == S_FILL) || (r_state == S_ABORT)) && !r_winner;
    assign req1_ack    = ((r_state == S_FILL) || (r_state == S_ABORT)) && r_winner;
    assign req_err     = (r_state == S_ABORT);
    assign busy        = (r_state != S_IDLE);
    assign buf_we      = w_beat;
    assign buf_waddr   = w_beat ? r_cnt : '0;
    assign buf_wdata   = w_beat ? bus_rdata : '0;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_biu_refill_ctrl.sv
// Directed bench for biu_refill_ctrl: nominal refill, round-robin, bus stalls,
// bus error abort, mid-burst reset and back-to-back requests.
module tb_biu_refill_ctrl;

  localparam int LINE_WORDS = 8;
  localparam int CNT_WIDTH  = 3;

  logic                 clk;
  logic                 rst;
  logic                 req0_valid;
  logic [31:0]          req0_addr;
  logic                 req0_ack;
  logic                 req1_valid;
  logic [31:0]          req1_addr;
  logic                 req1_ack;
  logic                 req_err;
  logic                 bus_req;
  logic [31:0]          bus_addr;
  logic                 bus_gnt;
  logic                 bus_rvalid;
  logic [31:0]          bus_rdata;
  logic                 bus_err;
  logic                 buf_we;
  logic [CNT_WIDTH-1:0] buf_waddr;
  logic [31:0]          buf_wdata;
  logic                 line_refill;
  logic [31:0]          refill_pa;
  logic                 busy;
  logic [2:0]           dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  biu_refill_ctrl #(.LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ack(req1_ack),
    .req_err(req_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .line_refill(line_refill), .refill_pa(refill_pa),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_buf_we"}, buf_we, 0);
    check({tag, "_buf_waddr"}, buf_waddr, 0);
    check({tag, "_line_refill"}, line_refill, 0);
    check({tag, "_refill_pa"}, refill_pa, 0);
    check({tag, "_ack0"}, req0_ack, 0);
    check({tag, "_ack1"}, req1_ack, 0);
    check({tag, "_req_err"}, req_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
    tick();
    tick();
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", dbg_state, 0);
    tick();
    rst = 1'b1;
  endtask

  // driver: one complete transaction, starting in an IDLE cycle (cycle 0)
  task automatic run_line(input logic v0, input logic v1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input int exp_port, input logic [31:0] exp_line,
                          input int gnt_delay, input int gap_beat, input int err_beat,
                          input int raise1_beat, input logic [31:0] dbase,
                          input int exp_end);
    int cyc;
    bit aborted;
    cyc = 0;
    aborted = 0;
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_bus_req", bus_req, 0);
    tick(); cyc++;
    for (int g = 0; g <= gnt_delay; g++) begin
      bus_gnt = (g == gnt_delay);
      bus_rvalid = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("addr_bus_req", bus_req, 1);
      check("addr_bus_addr", bus_addr, exp_line);
      check("addr_buf_we", buf_we, 0);
      check("addr_busy", busy, 1);
      tick(); cyc++;
    end
    bus_gnt = 0;
    bus_rvalid = 0;
    for (int b = 0; b < LINE_WORDS; b++) begin
      if (b == raise1_beat) req1_valid = 1'b1;
      if (b == gap_beat) begin
        bus_rvalid = 0;
        @(negedge clk);
        check("gap_buf_we", buf_we, 0);
        tick(); cyc++;
      end
      bus_rvalid = 1'b1;
      bus_rdata = dbase + 32'(b);
      if (b == err_beat) begin
        bus_err = 1'b1;
        @(negedge clk);
        check("err_buf_we", buf_we, 0);
        tick(); cyc++;
        aborted = 1;
        break;
      end
      @(negedge clk);
      check("data_buf_we", buf_we, 1);
      check("data_buf_waddr", buf_waddr, 32'(b));
      check("data_buf_wdata", buf_wdata, dbase + 32'(b));
      check("data_bus_req", bus_req, 0);
      tick(); cyc++;
    end
    bus_rvalid = 0;
    bus_err = 0;
    @(negedge clk);
    check("end_cycle", cyc, exp_end);
    check("end_ack0", req0_ack, exp_port == 0);
    check("end_ack1", req1_ack, exp_port == 1);
    check("end_req_err", req_err, aborted);
    check("end_line_refill", line_refill, !aborted);
    check("end_refill_pa", refill_pa, aborted ? 32'h0 : exp_line);
    check("end_buf_we", buf_we, 0);
    tick();
    if (exp_port == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  initial begin
    do_reset();

    // nominal port-0 refill, zero wait states
    run_line(1, 0, 32'h0000_1234, 32'h0, 0, 32'h0000_1220, 0, -1, -1, -1, 32'hA0, 10);

    // round robin: both valid three times -> 0, 1, 0
    do_reset();
    run_line(1, 1, 32'h0000_4444, 32'h1234_5678, 0, 32'h0000_4440, 0, -1, -1, -1, 32'h100, 10);
    run_line(1, 1, 32'h0000_ABCD, 32'h1234_5678, 1, 32'h1234_5660, 0, -1, -1, -1, 32'h200, 10);
    run_line(1, 1, 32'h0000_ABCD, 32'h1234_5678, 0, 32'h0000_ABC0, 0, -1, -1, -1, 32'h300, 10);
    req1_valid = 0;

    // gnt delayed 3 cycles, one rvalid gap after beat 4
    run_line(0, 1, 32'h0, 32'h8000_00FC, 1, 32'h8000_00E0, 3, 5, -1, -1, 32'h400, 14);

    // bus error together with beat 5 on port 1
    run_line(0, 1, 32'h0, 32'h0000_0040, 1, 32'h0000_0040, 0, -1, 5, -1, 32'h500, 8);
    @(negedge clk);
    check("post_abort_busy", busy, 0);
    check("post_abort_refill", line_refill, 0);

    // reset asserted in DATA after beat 3
    req0_valid = 1; req0_addr = 32'h5555_5555;
    @(negedge clk);
    tick();
    bus_gnt = 1;
    @(negedge clk);
    check("rst_run_bus_req", bus_req, 1);
    tick();
    bus_gnt = 0;
    for (int b = 0; b < 4; b++) begin
      bus_rvalid = 1; bus_rdata = 32'h600 + 32'(b);
      @(negedge clk);
      check("rst_run_we", buf_we, 1);
      tick();
    end
    bus_rvalid = 1; bus_rdata = 32'h604;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    req0_valid = 0;
    tick();
    @(negedge clk);
    check_all_zero("rst_held");
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all_zero("rst_after");
      tick();
    end
    bus_rvalid = 0;
    run_line(1, 1, 32'h0000_2010, 32'h0000_3000, 0, 32'h0000_2000, 0, -1, -1, -1, 32'h700, 10);
    req1_valid = 0;

    // port 1 raises during port 0 DATA, granted in the IDLE cycle right after FILL
    run_line(1, 0, 32'h0000_7F7F, 32'h0000_9008, 0, 32'h0000_7F60, 0, -1, -1, 2, 32'h800, 10);
    run_line(0, 1, 32'h0, 32'h0000_9008, 1, 32'h0000_9000, 0, -1, -1, -1, 32'h900, 10);
    @(negedge clk);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/biu_refill_ctrl.md
# biu_refill_ctrl

Line-refill controller for the BIU tag/entry buffer. It arbitrates miss requests from two requesters (port 0 and port 1) with round-robin priority. For the winning request it issues one line-aligned burst read on the system bus, streams the returned words into the entry buffer at the slot chosen by the tag arbiter, then pulses `line_refill` with the line physical address so the arbiter installs the tag. It also acknowledges the requester so it can retry its lookup.

## Interface
- `LINE_WORDS`, 8: 32-bit words per line; power of two, ≥2.
- `CNT_WIDTH`, $clog2(LINE_WORDS): beat counter / buffer word index width.
- `LINE_OFFSET`, $clog2(LINE_WORDS)+2: byte-offset bits cleared in line address.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  port 0 miss request; held until ack.
- `req0_addr`  in  32  port 0 miss address; stable while valid.
- `req0_ack`  out  1  1-cycle pulse; port 0 request completed.
- `req1_valid`, `req1_addr`, `req1_ack`: same as port 0, for port 1.
- `req_err`  out  1  qualifies ack; 1 means bus error, line not installed.
- `bus_req`  out  1  burst read address phase request.
- `bus_addr`  out  32  line-aligned burst address.
- `bus_gnt`  in  1  bus accepted address phase.
- `bus_rvalid`  in  1  read data beat valid.
- `bus_rdata`  in  32  read data beat.
- `bus_err`  in  1  bus error; valid in ADDR or DATA.
- `buf_we`  out  1  entry buffer word write enable.
- `buf_waddr`  out  CNT_WIDTH  word index within line.
- `buf_wdata`  out  32  word data.
- `line_refill`  out  1  1-cycle pulse to tag arbiter: install tag.
- `refill_pa`  out  32  line-aligned address, valid with `line_refill`.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, ADDR, DATA, FILL, ABORT.
- IDLE: sample `req0_valid` and `req1_valid`.
  - One valid: grant it.
  - Both valid: grant the port selected by priority pointer `rr_ptr`.
  - On grant: latch the winner id and `line_addr = {reqN_addr[31:LINE_OFFSET], LINE_OFFSET'b0}`; flip `rr_ptr` to the non-winner; clear the beat counter; go to ADDR.
- ADDR: `bus_req`=1 and `bus_addr`=`line_addr`, held until a cycle where `bus_gnt`=1, then go to DATA. `bus_rvalid` is ignored in ADDR.
- DATA: each cycle with `bus_rvalid`=1:
  - Combinationally drive `buf_we`=1, `buf_waddr`=beat counter, `buf_wdata`=`bus_rdata`.
  - Increment the counter.
  - On beat `LINE_WORDS-1`, go to FILL. The counter wraps to 0 without overflow affecting the output.
- FILL (1 cycle): `line_refill`=1, `refill_pa`=`line_addr`, `reqN_ack`=1 for the winner, `req_err`=0. Then go to IDLE.
- ABORT (1 cycle): entered on `bus_err`=1 in ADDR or DATA; `bus_err` takes precedence over `bus_gnt`/`bus_rvalid` in the same cycle. Drives `reqN_ack`=1 and `req_err`=1; no `line_refill`, no further `buf_we`. Then go to IDLE.
- Requesters deassert valid on the edge where they see ack. A request that remains valid after ack is treated as a new miss.
- The replace slot is owned by the tag arbiter. This block never drives `buf_we` outside DATA.

## Timing
- Reset (`rst`=0, async): state IDLE, `rr_ptr` = port 0.
  - Outputs forced to 0: `bus_req`, `bus_addr`, `buf_we`, `buf_waddr`, `line_refill`, `refill_pa`, `req0_ack`, `req1_ack`, `req_err`, `busy`.
  - Reset mid-burst: no ack, no `line_refill`; bus beats after reset are ignored.
- All outputs are registered (state-decoded), except the `buf_*` pass-through in DATA.
- Latency, zero bus wait states: request visible in cycle 0, `bus_req` in cycle 1, gnt in cycle 1, beats in cycles 2..LINE_WORDS+1, FILL/ack in cycle LINE_WORDS+2. Default: cycle 10.
- Bus stalls add cycles 1:1: gnt delay extends ADDR; rvalid gaps extend DATA.
- Ack and `line_refill` occur in the same cycle. The tag is visible to lookups from the next cycle.
- Back-to-back: the earliest next grant is the IDLE cycle after FILL/ABORT. Minimum request spacing is LINE_WORDS+3 cycles.
- Requests arriving while busy are held by the requester and not lost.

## Test plan
- Reset then single port-0 miss at `0x0000_1234`, gnt immediate, 8 back-to-back beats `0xA0..0xA7`:
  - `bus_addr`=`0x0000_1220`.
  - `buf_waddr` 0..7 with matching data.
  - `line_refill`, `refill_pa`=`0x0000_1220`, and `req0_ack` in cycle 10.
- Both ports valid in the same cycle, twice in a row: first grant port 0, second grant port 1. A third simultaneous request is granted to port 0.
- Gnt delayed 3 cycles and one rvalid gap after beat 4: `bus_req` held 4 cycles; ack in cycle 14; no `buf_we` during the gap or ADDR.
- `bus_err` on beat 5, with `bus_rvalid` also 1: no `buf_we` that cycle; next cycle `req1_ack`=1 and `req_err`=1; no `line_refill`; then `busy`=0.
- `rst` asserted in DATA after beat 3: all outputs 0 immediately; no ack or `line_refill`. A fresh request afterwards completes normally and is granted to port 0.
- Port 1 requests while port 0 is in DATA: port 1 is granted the cycle after port 0's FILL, and `bus_req` rises one cycle later.
